// File: rtl/operand_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_loader_if : beat stream in, operand pair out                 |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface operand_loader_if #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 8
);
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, A, B, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, A, B, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_loader : assembles A/B operands from narrow beats and        |
// | presents them as a registered pair. OPERAND_LOADER_MSB_FIRST_EN      |
// | selects MSB-first beat order (default LSB-first).                    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module operand_loader #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 8,
  localparam int BEATS = DATA_W / IN_W,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clear,
  operand_loader_if.slave    bus,
  output      logic [CW-1:0] beat_cnt,
  output      logic          loading_b
);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(BEATS - 1);

  state_t              r_state;
  logic [CW-1:0]       r_beat_cnt;
  logic [DATA_W-1:0]   r_shift_a;
  logic [DATA_W-1:0]   r_shift_b;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_loading_b;

  logic                w_accept;
  logic                w_last;
  logic [DATA_W-1:0]   w_shift_a_nxt;
  logic [DATA_W-1:0]   w_shift_b_nxt;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_last   = (r_beat_cnt == C_LAST);

`ifdef OPERAND_LOADER_MSB_FIRST_EN
  assign w_shift_a_nxt = {r_shift_a[DATA_W-IN_W-1:0], bus.in_data};
  assign w_shift_b_nxt = {r_shift_b[DATA_W-IN_W-1:0], bus.in_data};
`else
  assign w_shift_a_nxt = {bus.in_data, r_shift_a[DATA_W-1:IN_W]};
  assign w_shift_b_nxt = {bus.in_data, r_shift_b[DATA_W-1:IN_W]};
`endif

  // in_ready and out_valid are registered alongside the state so they
  // always match it without a decode path on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD_A;
      r_beat_cnt  <= '0;
      r_shift_a   <= '0;
      r_shift_b   <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_loading_b <= 1'b0;
    end else if (clear) begin
      r_state     <= S_LOAD_A;
      r_beat_cnt  <= '0;
      r_shift_a   <= '0;
      r_shift_b   <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_loading_b <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (w_accept) begin
            r_shift_a <= w_shift_a_nxt;
            if (w_last) begin
              r_beat_cnt  <= '0;
              r_state     <= S_LOAD_B;
              r_loading_b <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (w_accept) begin
            r_shift_b <= w_shift_b_nxt;
            if (w_last) begin
              r_beat_cnt  <= '0;
              r_a         <= r_shift_a;
              r_b         <= w_shift_b_nxt;
              r_state     <= S_PRESENT;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_loading_b <= 1'b0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        S_PRESENT: begin
          // A/B stay as presented until the next pair lands.
          if (bus.out_ready) begin
            r_state     <= S_LOAD_A;
            r_shift_a   <= '0;
            r_shift_b   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_LOAD_A;
          r_beat_cnt  <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_loading_b <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.A         = r_a;
  assign bus.B         = r_b;
  assign beat_cnt      = r_beat_cnt;
  assign loading_b     = r_loading_b;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_operand_loader : directed bench for operand_loader                |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [1:0] beat_cnt;
  logic       loading_b;

  int total  = 0;
  int passed = 0;

  operand_loader_if #(.DATA_W(32), .IN_W(8)) ifc ();

  operand_loader #(.DATA_W(32), .IN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (ifc.slave),
    .beat_cnt  (beat_cnt),
    .loading_b (loading_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] beat_of(input logic [31:0] v, input int k);
`ifdef OPERAND_LOADER_MSB_FIRST_EN
    return v[(3-k)*8 +: 8];
`else
    return v[k*8 +: 8];
`endif
  endfunction

  task automatic send_beat(input logic [7:0] d);
    ifc.in_data  = d;
    ifc.in_valid = 1'b1;
    tick();
  endtask

  // Sends one operand; with gap>0 each beat is followed by idle cycles.
  task automatic send_op(input logic [31:0] v, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_beat(beat_of(v, k));
      if (gap > 0) begin
        ifc.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          check("gap_beat_cnt", 32'(beat_cnt), 32'((k + 1) % 4));
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    ifc.in_data   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_A", ifc.A, 32'h0);
    check("rst_B", ifc.B, 32'h0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_loading_b", 32'(loading_b), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic pair, in_valid held high, out_ready=1
    send_op(32'h0000FFFF, 0);
    check("t1_loading_b", 32'(loading_b), 32'd1);
    check("t1_cnt_wrap", 32'(beat_cnt), 32'd0);
    for (int k = 0; k < 3; k++) send_beat(beat_of(32'h00FF00FF, k));
    check("t1_cnt3", 32'(beat_cnt), 32'd3);
    check("t1_no_valid_early", 32'(ifc.out_valid), 32'd0);
    send_beat(beat_of(32'h00FF00FF, 3));
    check("t1_out_valid", 32'(ifc.out_valid), 32'd1);
    check("t1_A", ifc.A, 32'h0000FFFF);
    check("t1_B", ifc.B, 32'h00FF00FF);
    check("t1_nor", ~(ifc.A | ifc.B), 32'hFF000000);
    check("t1_in_ready_present", 32'(ifc.in_ready), 32'd0);
    tick();
    check("t1_consumed", 32'(ifc.out_valid), 32'd0);
    check("t1_back_load_a", 32'(ifc.in_ready), 32'd1);
    check("t1_back_cnt", 32'(beat_cnt), 32'd0);
    check("t1_back_loading_b", 32'(loading_b), 32'd0);
    ifc.in_valid = 1'b0;

    // Backpressure for 5 cycles, in_valid held high and ignored
    ifc.out_ready = 1'b0;
    send_op(32'h0000FFFF, 0);
    send_op(32'h00FF00FF, 0);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(ifc.out_valid), 32'd1);
      check("t2_hold_A", ifc.A, 32'h0000FFFF);
      check("t2_hold_B", ifc.B, 32'h00FF00FF);
      check("t2_in_ready", 32'(ifc.in_ready), 32'd0);
      tick();
    end
    check("t2_hold_cnt", 32'(beat_cnt), 32'd0);
    ifc.out_ready = 1'b1;
    tick();
    check("t2_handshake", 32'(ifc.out_valid), 32'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;

    // in_valid gaps: 1,0,0,1,0,0,...
    send_op(32'h0000FFFF, 2);
    send_op(32'h00FF00FF, 2);
    check("t3_out_valid", 32'(ifc.out_valid), 32'd1);
    check("t3_A", ifc.A, 32'h0000FFFF);
    check("t3_B", ifc.B, 32'h00FF00FF);

    // Abort mid-B with clear, then a fresh full load
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    send_op(32'h11223344, 0);
    for (int k = 0; k < 3; k++) send_beat(beat_of(32'hAABBCCDD, k));
    check("t4_pre_loading_b", 32'(loading_b), 32'd1);
    check("t4_pre_cnt", 32'(beat_cnt), 32'd3);
    clear = 1'b1;
    send_beat(beat_of(32'hAABBCCDD, 3));
    clear        = 1'b0;
    ifc.in_valid = 1'b0;
    check("t4_clr_cnt", 32'(beat_cnt), 32'd0);
    check("t4_clr_loading_b", 32'(loading_b), 32'd0);
    check("t4_clr_out_valid", 32'(ifc.out_valid), 32'd0);
    check("t4_clr_in_ready", 32'(ifc.in_ready), 32'd1);
    check("t4_clr_A_kept", ifc.A, 32'h0000FFFF);
    check("t4_clr_B_kept", ifc.B, 32'h00FF00FF);
    send_op(32'h12345678, 0);
    check("t4_mid_A_kept", ifc.A, 32'h0000FFFF);
    send_op(32'h9ABCDEF0, 0);
    ifc.in_valid = 1'b0;
    check("t4_out_valid", 32'(ifc.out_valid), 32'd1);
    check("t4_A", ifc.A, 32'h12345678);
    check("t4_B", ifc.B, 32'h9ABCDEF0);

    // Asynchronous reset while presenting
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_out_valid", 32'(ifc.out_valid), 32'd0);
    check("t5_async_A", ifc.A, 32'h0);
    check("t5_async_B", ifc.B, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_in_ready", 32'(ifc.in_ready), 32'd1);
    check("t5_beat_cnt", 32'(beat_cnt), 32'd0);
    check("t5_out_valid", 32'(ifc.out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
